// File: rtl/switch_stm_demux.sv
// rtl/switch_stm_demux.sv - one-input, three-output stream demux with per-port one-entry buffers
//
// Routes each accepted input word to one of three output ports by din_sel.
// Select values 3..7 are unmapped: those words are accepted and discarded,
// and drop_cnt counts them (saturating at 255).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din_data/sel/vld    input word, destination select, valid
//   din_rd              input accepted this cycle (combinational)
//   dout{0,1,2}_data    registered output word of each port
//   dout{0,1,2}_vld     port buffer holds a word
//   dout{0,1,2}_rd      sink of each port accepts the word
//   drop_cnt            saturating count of discarded words

module switch_stm_demux #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic [2:0]            din_sel,
    input  logic                  din_vld,
    output logic                  din_rd,
    output logic [DATA_WIDTH-1:0] dout0_data,
    output logic                  dout0_vld,
    input  logic                  dout0_rd,
    output logic [DATA_WIDTH-1:0] dout1_data,
    output logic                  dout1_vld,
    input  logic                  dout1_rd,
    output logic [DATA_WIDTH-1:0] dout2_data,
    output logic                  dout2_vld,
    input  logic                  dout2_rd,
    output logic [7:0]            drop_cnt
);

    logic [2:0]            full;
    logic [2:0]            sink_rd;
    logic [2:0]            load;
    logic [2:0]            drain;
    logic                  drop;
    logic [DATA_WIDTH-1:0] data_q [3];

    assign sink_rd = {dout2_rd, dout1_rd, dout0_rd};
    assign drain   = full & sink_rd;

    // A port can take a new word when empty or when its current word leaves
    // this same cycle; the replacement then lands without a bubble.
    // din_rd depends only on the presented select, never on din_vld.
    always_comb begin
        din_rd = 1'b1;
        load   = 3'b000;
        drop   = 1'b0;
        case (din_sel)
            3'd0: begin
                din_rd  = ~full[0] | sink_rd[0];
                load[0] = din_vld & din_rd;
            end
            3'd1: begin
                din_rd  = ~full[1] | sink_rd[1];
                load[1] = din_vld & din_rd;
            end
            3'd2: begin
                din_rd  = ~full[2] | sink_rd[2];
                load[2] = din_vld & din_rd;
            end
            default: begin
                drop = din_vld;
            end
        endcase
    end

    // Load wins over drain so a simultaneous drain+load keeps the port full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 3'b000;
            drop_cnt <= 8'd0;
        end else begin
            full <= load | (full & ~drain);
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Data registers carry no reset; their contents only matter while full.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (load[i]) begin
                data_q[i] <= din_data;
            end
        end
    end

    assign dout0_data = data_q[0];
    assign dout1_data = data_q[1];
    assign dout2_data = data_q[2];
    assign dout0_vld  = full[0];
    assign dout1_vld  = full[1];
    assign dout2_vld  = full[2];

endmodule

// File: tb/tb_switch_stm_demux.sv
// tb/tb_switch_stm_demux.sv - self-checking bench for switch_stm_demux

module tb_switch_stm_demux;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din_data;
    logic [2:0]    din_sel;
    logic          din_vld;
    logic          din_rd;
    logic [2:0][DW-1:0] dd;
    logic [2:0]    dvld;
    logic [2:0]    drd;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    switch_stm_demux #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_data   (din_data),
        .din_sel    (din_sel),
        .din_vld    (din_vld),
        .din_rd     (din_rd),
        .dout0_data (dd[0]),
        .dout0_vld  (dvld[0]),
        .dout0_rd   (drd[0]),
        .dout1_data (dd[1]),
        .dout1_vld  (dvld[1]),
        .dout1_rd   (drd[1]),
        .dout2_data (dd[2]),
        .dout2_vld  (dvld[2]),
        .dout2_rd   (drd[2]),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each port is an in-order queue of words it holds,
    // plus an integer count of discarded words.
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];
    int            mdrop;
    bit            macc;

    function automatic bit exp_rd();
        case (din_sel)
            3'd0:    return (q0.size() == 0) || drd[0];
            3'd1:    return (q1.size() == 0) || drd[1];
            3'd2:    return (q2.size() == 0) || drd[2];
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            q2.delete();
            mdrop = 0;
        end else begin
            macc = din_vld && exp_rd();
            if (q0.size() > 0 && drd[0]) void'(q0.pop_front());
            if (q1.size() > 0 && drd[1]) void'(q1.pop_front());
            if (q2.size() > 0 && drd[2]) void'(q2.pop_front());
            if (macc) begin
                case (din_sel)
                    3'd0:    q0.push_back(din_data);
                    3'd1:    q1.push_back(din_data);
                    3'd2:    q2.push_back(din_data);
                    default: if (mdrop < 255) mdrop++;
                endcase
            end
        end
    end

    // Compare process: every cycle out of reset, outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("din_rd", {31'd0, din_rd}, {31'd0, exp_rd()});
            chk("vld0", {31'd0, dvld[0]}, {31'd0, q0.size() != 0});
            chk("vld1", {31'd0, dvld[1]}, {31'd0, q1.size() != 0});
            chk("vld2", {31'd0, dvld[2]}, {31'd0, q2.size() != 0});
            if (q0.size() != 0) chk("data0", {24'd0, dd[0]}, {24'd0, q0[0]});
            if (q1.size() != 0) chk("data1", {24'd0, dd[1]}, {24'd0, q1[0]});
            if (q2.size() != 0) chk("data2", {24'd0, dd[2]}, {24'd0, q2[0]});
            chk("drop_cnt", {24'd0, drop_cnt}, mdrop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        drd     = 3'b111;
        din_vld = 1'b0;
        step();
        step();
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        din_data = '0;
        din_sel  = 3'd0;
        din_vld  = 1'b0;
        drd      = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_vld", {29'd0, dvld}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("rst_din_rd", {31'd0, din_rd}, 32'd1);

        // Single word to port 0.
        step();
        din_data = 8'hA5; din_sel = 3'd0; din_vld = 1'b1; drd = 3'b001;
        step();
        din_vld = 1'b0;
        @(negedge clk);
        chk("t030_vld0", {31'd0, dvld[0]}, 32'd1);
        chk("t030_data0", {24'd0, dd[0]}, 32'hA5);
        chk("t030_vld12", {30'd0, dvld[2:1]}, 32'd0);
        chk("t030_model", {24'd0, q0[0]}, 32'hA5);

        // Stalled port 1, then drain and load in the same cycle.
        flush();
        drd = 3'b000;
        din_data = 8'h11; din_sel = 3'd1; din_vld = 1'b1;
        @(negedge clk);
        chk("t031_rd_first", {31'd0, din_rd}, 32'd1);
        step();
        din_data = 8'h22;
        @(negedge clk);
        chk("t031_rd_second", {31'd0, din_rd}, 32'd0);
        chk("t031_data_11", {24'd0, dd[1]}, 32'h11);
        step();
        drd[1] = 1'b1;
        @(negedge clk);
        chk("t031_rd_release", {31'd0, din_rd}, 32'd1);
        chk("t031_still_11", {24'd0, dd[1]}, 32'h11);
        step();
        din_vld = 1'b0;
        @(negedge clk);
        chk("t031_vld1", {31'd0, dvld[1]}, 32'd1);
        chk("t031_data_22", {24'd0, dd[1]}, 32'h22);

        // Port 2 stalled does not block port 0.
        flush();
        drd = 3'b000;
        din_data = 8'h77; din_sel = 3'd2; din_vld = 1'b1;
        step();
        din_data = 8'h33; din_sel = 3'd0;
        @(negedge clk);
        chk("t032_rd", {31'd0, din_rd}, 32'd1);
        step();
        din_vld = 1'b0;
        @(negedge clk);
        chk("t032_data2", {24'd0, dd[2]}, 32'h77);
        chk("t032_data0", {24'd0, dd[0]}, 32'h33);

        // Randomised traffic against the model.
        flush();
        for (int n = 0; n < 1500; n++) begin
            step();
            din_vld  = ($urandom % 4) != 0;
            din_sel  = (($urandom % 4) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2, 0));
            din_data = DW'($urandom);
            drd      = 3'($urandom);
        end

        // Discard saturation.
        do_reset();
        drd = 3'b000;
        for (int n = 0; n < 300; n++) begin
            din_data = DW'($urandom); din_sel = 3'd5; din_vld = 1'b1;
            @(negedge clk);
            chk("t033_rd", {31'd0, din_rd}, 32'd1);
            chk("t033_novld", {29'd0, dvld}, 32'd0);
            step();
        end
        din_vld = 1'b0;
        @(negedge clk);
        chk("t033_drop", {24'd0, drop_cnt}, 32'd255);

        // Back-to-back stream on port 2.
        step();
        drd = 3'b100;
        for (int k = 0; k < 20; k++) begin
            din_data = DW'(8'h40 + k); din_sel = 3'd2; din_vld = 1'b1;
            @(negedge clk);
            if (k > 0) begin
                chk("t034_vld2", {31'd0, dvld[2]}, 32'd1);
                chk("t034_data2", {24'd0, dd[2]}, 32'h40 + k - 1);
            end
            step();
        end
        din_vld = 1'b0;
        @(negedge clk);
        chk("t034_last", {24'd0, dd[2]}, 32'h53);

        // Asynchronous reset with ports 0 and 1 full.
        step();
        drd = 3'b000;
        din_data = 8'h5A; din_sel = 3'd0; din_vld = 1'b1;
        step();
        din_data = 8'h6B; din_sel = 3'd1;
        step();
        din_vld = 1'b0;
        @(negedge clk);
        chk("t035_full", {30'd0, dvld[1:0]}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t035_vld", {30'd0, dvld[1:0]}, 32'd0);
        chk("t035_drop", {24'd0, drop_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t035_after", {29'd0, dvld}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_stm_demux.md
SWITCH_STM_DEMUX -- requirements
Module: switch_stm_demux

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of the data path in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 din_data  input  DATA_WIDTH  input word.
REQ-005 din_sel  input  3  destination select, qualified by din_vld.
REQ-006 din_vld  input  1  input word and select are valid.
REQ-007 din_rd  output  1  block accepts the input this cycle.
REQ-008 dout{i}_data  output  DATA_WIDTH  output word of port i (i = 0, 1, 2).
REQ-009 dout{i}_vld  output  1  port i holds a valid word.
REQ-010 dout{i}_rd  input  1  sink of port i accepts the word.
REQ-011 drop_cnt  output  8  count of words discarded for an unmapped select.

Function
REQ-012 Transfers: input transfer = din_vld & din_rd; port-i transfer = dout{i}_vld & dout{i}_rd, both in the same cycle.
REQ-013 Routing: din_sel 3'b000 -> port 0, 3'b001 -> port 1, 3'b010 -> port 2; 3'b011..3'b111 -> discard.
REQ-014 Buffering: each port has a one-entry register (data + full flag); dout{i}_vld is that full flag; dout{i}_data is the registered word.
REQ-015 din_rd is combinational: for mapped sel = i, ~full_i | dout{i}_rd; for unmapped sel, 1.
REQ-016 din_rd is independent of din_vld; when din_vld = 0 it still reflects the currently presented din_sel.
REQ-017 Latency: a word accepted in cycle N is presented at its port with dout{i}_vld = 1 from cycle N+1.
REQ-018 Per port, next full_i: 1 if an input transfer targets port i; else 0 if a port-i transfer occurs; else unchanged.
REQ-019 Simultaneous port-i drain and port-i load: the new word replaces the old one, full_i stays 1, and no bubble is inserted (full throughput per port).
REQ-020 Ports are independent: a stalled port (dout{i}_rd = 0, full) blocks only input words addressed to it.
REQ-021 Words addressed to the same port leave it in acceptance order; there is no reordering within a port.
REQ-022 dout{i}_data is held stable while dout{i}_vld = 1 and dout{i}_rd = 0.
REQ-023 Discard: an input transfer with an unmapped select updates no port and increments drop_cnt by 1.
REQ-024 drop_cnt saturates at 255 and does not wrap.
REQ-025 Data-path register loads occur only on input transfers; at other times the data registers hold their value.

Reset
REQ-026 While rst_n = 0: full_0..2 = 0 (all dout{i}_vld = 0) and drop_cnt = 0.
REQ-027 Data registers are not reset; their contents are don't-care while the matching valid flag is 0.
REQ-028 Reset asserted mid-operation discards buffered words immediately, without waiting for a clock edge.
REQ-029 After rst_n is released, the first rising edge may accept a word; din_rd follows REQ-015 with all buffers empty.

Verification
REQ-030 Reset, then din_data = 8'hA5, din_sel = 0, din_vld = 1 for one cycle with dout0_rd = 1 -> next cycle dout0_vld = 1 and dout0_data = 8'hA5; dout1_vld = dout2_vld = 0.
REQ-031 dout1_rd = 0; send 8'h11 then 8'h22 to sel = 1 -> the first is accepted, din_rd = 0 for the second; raise dout1_rd -> 8'h11 drains and 8'h22 is accepted in the same cycle.
REQ-032 Port 2 full and stalled; send sel = 0 word 8'h33 -> accepted with din_rd = 1; port 2 data is unchanged.
REQ-033 Send 300 words with din_sel = 3'b101 -> din_rd = 1 throughout, no dout{i}_vld asserts, and drop_cnt ends at 255.
REQ-034 Continuous stream to sel = 2 with dout2_rd = 1 -> one word per cycle at port 2, in order, with no gaps.
REQ-035 Assert rst_n = 0 asynchronously while ports 0 and 1 are full -> dout0_vld = dout1_vld = 0 and drop_cnt = 0 before the next clock edge.
